// File: rtl/bpu_btb_if.sv
// ----------------------------------------------------------------------------
// bpu_btb_if
// Groups the fetch-lookup, EX-update and return-stack signals of the branch
// target buffer into one bundle.
//
// Modports
//   slave  : the BTB itself (consumes lookup/update/stack, produces predictions)
//   master : the pipeline side (drives lookup/update/stack, reads predictions)
//
// Signals
//   lookup_pc     fetch PC, looked up combinationally
//   pred_hit      valid entry with matching tag
//   pred_taken    pred_hit AND counter MSB
//   pred_target   predicted target, 0 on miss
//   pred_state    counter of the hit entry, 0 on miss
//   upd_valid     resolved branch/jump in EX this cycle
//   upd_pc        PC of the resolved instruction
//   upd_taken     actual outcome
//   upd_target    actual target
//   upd_is_ret    resolved instruction is a jr (stored as entry kind)
//   ras_push      jal resolved in EX (only used when BPU_RAS_EN is defined)
//   ras_push_addr PC+1 of that jal
//   ras_pop       jr resolved in EX (only used when BPU_RAS_EN is defined)
//
// There is no backpressure anywhere in this bundle: an asserted upd_valid,
// ras_push or ras_pop is consumed on the next rising clock edge
// unconditionally, and the lookup result is valid in the same cycle the PC
// is presented.
// ----------------------------------------------------------------------------
interface bpu_btb_if #(
    parameter int PC_W  = 10,
    parameter int CTR_W = 2
);
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [CTR_W-1:0] pred_state;

    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             upd_is_ret;

    logic             ras_push;
    logic [PC_W-1:0]  ras_push_addr;
    logic             ras_pop;

    modport slave (
        input  lookup_pc,
        output pred_hit, pred_taken, pred_target, pred_state,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_ret,
        input  ras_push, ras_push_addr, ras_pop
    );

    modport master (
        output lookup_pc,
        input  pred_hit, pred_taken, pred_target, pred_state,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_is_ret,
        output ras_push, ras_push_addr, ras_pop
    );
endinterface

// File: rtl/bpu_btb.sv
// ----------------------------------------------------------------------------
// bpu_btb
// Direct-mapped branch target buffer with per-entry saturating counters.
// Fetch looks up a PC combinationally from registered state (zero latency);
// EX trains the table with resolved outcomes on the rising clock edge.
// A taken branch that misses allocates an entry in weakly-taken state.
//
// Optional build feature (macro BPU_RAS_EN): a circular return address stack.
// A hit on an entry whose kind bit marks it as a return (jr) then predicts the
// stack top when the stack is non-empty. Without the macro the ras_* inputs
// are ignored and the kind bit is stored but unused.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears table and stack, overrides
//        any same-cycle update or push/pop
//   bus  bpu_btb_if.slave (lookup, prediction, update and stack signals)
//
// Parameters
//   PC_W      width of PCs and targets
//   DEPTH     number of entries (power of 2, >= 2)
//   CTR_W     counter width (1..4)
//   RAS_DEPTH return stack entries (power of 2), BPU_RAS_EN builds only
// ----------------------------------------------------------------------------
module bpu_btb #(
    parameter int PC_W      = 10,
    parameter int DEPTH     = 16,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    bpu_btb_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    // Weakly taken: only the MSB set (for CTR_W=1 this is simply 1).
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] kind_q,  kind_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [PC_W-1:0]  target_d [DEPTH];
    logic [CTR_W-1:0] ctr_q    [DEPTH];
    logic [CTR_W-1:0] ctr_d    [DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign lk_idx = bus.lookup_pc[IDX_W-1:0];
    assign lk_tag = bus.lookup_pc[PC_W-1:IDX_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign up_idx = bus.upd_pc[IDX_W-1:0];
    assign up_tag = bus.upd_pc[PC_W-1:IDX_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

`ifdef BPU_RAS_EN
    // ------------------------------------------------------------------
    // Return address stack
    // ------------------------------------------------------------------
    localparam int RAS_IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]      ras_q [RAS_DEPTH];
    logic [PC_W-1:0]      ras_d [RAS_DEPTH];
    logic [RAS_IDX_W-1:0] top_q, top_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RAS_IDX_W-1:0] top_inc;
    logic [RAS_IDX_W-1:0] top_dec;

    assign top_inc = top_q + 1'b1;
    assign top_dec = top_q - 1'b1;

    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (bus.ras_push && bus.ras_pop) begin
            // A call and a return retiring together net to a top replacement.
            ras_d[top_q] = bus.ras_push_addr;
        end else if (bus.ras_push) begin
            // Circular buffer: when full the write lands on the oldest entry.
            ras_d[top_inc] = bus.ras_push_addr;
            top_d          = top_inc;
            if (cnt_q != RAS_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.ras_pop && (cnt_q != '0)) begin
            top_d = top_dec;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // Stack inputs and the kind bit have no consumer in this build.
    logic unused_ras;
    assign unused_ras = ^{bus.ras_push, bus.ras_push_addr, bus.ras_pop, kind_q};
`endif

    // ------------------------------------------------------------------
    // Lookup (combinational, no bypass from a same-cycle update)
    // ------------------------------------------------------------------
    always_comb begin
        bus.pred_hit    = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        bus.pred_state  = '0;
        if (lk_hit) begin
            bus.pred_hit    = 1'b1;
            bus.pred_taken  = ctr_q[lk_idx][CTR_W-1];
            bus.pred_target = target_q[lk_idx];
            bus.pred_state  = ctr_q[lk_idx];
`ifdef BPU_RAS_EN
            if (kind_q[lk_idx] && (cnt_q != '0)) begin
                bus.pred_target = ras_q[top_q];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Training. Counter math uses the stored counter, never the value the
    // pipeline carried from fetch, so back-to-back updates compound.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        kind_d   = kind_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 1'b1;
                    end
                    target_d[up_idx] = bus.upd_target;
                    kind_d[up_idx]   = bus.upd_is_ret;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 1'b1;
                end
            end else if (bus.upd_taken) begin
                // Allocate, evicting whatever aliased into this slot.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                kind_d[up_idx]   = bus.upd_is_ret;
                ctr_d[up_idx]    = CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            kind_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            kind_q   <= kind_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end
endmodule
